regfile_scoreboard: RTL



---
 rtl/regfile_scoreboard.sv | 115 +++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with r0 tied to zero, write-to-read bypass,
// per-register busy (scoreboard) bits and a sequential bulk-clear engine.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  rbusy_a,
  output logic                  rbusy_b,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wr_ready,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] cnt, cnt_next;
  logic                  done_next;
  logic                  wr_acc, rsv_acc;

  assign wr_ready = (state == IDLE);
  assign clr_busy = (state == CLEAR);
  assign wr_acc   = we     & wr_ready & ~rst & (waddr    != '0);
  assign rsv_acc  = rsv_en & wr_ready & ~rst & (rsv_addr != '0);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          cnt_next   = ADDR_WIDTH'(1);
        end
      end
      CLEAR: begin
        if (cnt == '1) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt + ADDR_WIDTH'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reserve is applied after the write so it wins on a same-address collision.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy     <= '0;
      state    <= IDLE;
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      clr_done <= done_next;
      if (state == CLEAR) begin
        regs[cnt] <= '0;
        busy[cnt] <= 1'b0;
      end
      if (wr_acc) begin
        regs[waddr] <= wdata;
        busy[waddr] <= 1'b0;
      end
      if (rsv_acc) busy[rsv_addr] <= 1'b1;
    end
  end

  always_comb begin
    rdata_a = '0;
    rbusy_a = 1'b0;
    if (raddr_a != '0) begin
      if (wr_acc && (waddr == raddr_a)) begin
        rdata_a = wdata;
      end else begin
        rdata_a = regs[raddr_a];
        rbusy_a = busy[raddr_a];
      end
    end
  end

  always_comb begin
    rdata_b = '0;
    rbusy_b = 1'b0;
    if (raddr_b != '0) begin
      if (wr_acc && (waddr == raddr_b)) begin
        rdata_b = wdata;
      end else begin
        rdata_b = regs[raddr_b];
        rbusy_b = busy[raddr_b];
      end
    end
  end

endmodule
